jtframe_hsize_ctrl: RTL and testbench
=====================================

Name: jtframe_hsize_ctrl

Overview:
- Configuration controller for the horizontal scaler. Takes user step commands (scale/offset up/down, enable toggle) from the OSD/button layer and holds them in shadow registers.
- Commits shadow values to the scaler's scale/offset/enable inputs only at the rising edge of VB, so no frame is ever rendered with mixed settings.
- Measures active line width (HB low, in pixels) for status display.
- Watches HS and forces the scaler into bypass when sync is lost.

Parameters:
- SCREEN_WIDTH, 384, total pixels per line including blanking; sizes the width counter.
- SCALE_RST, 4'd8, scale value loaded at reset (unity, 1:1).
- OFFSET_RST, 5'd0, offset value loaded at reset.
- REPEAT_DLY, 24, frames a step input must be held before auto-repeat starts.
- REPEAT_PER, 4, frames between auto-repeat steps.
- HS_TIMEOUT, 2048, pxl_cen ticks without an HS rising edge before sync is declared lost.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, synchronous active-low.
- pxl_cen, input, 1, pixel clock enable.
- HS, input, 1, horizontal sync (active high).
- HB, input, 1, horizontal blank.
- VB, input, 1, vertical blank.
- scale_up, input, 1, level; request scale+1.
- scale_dn, input, 1, level; request scale-1.
- offset_up, input, 1, level; request offset+1.
- offset_dn, input, 1, level; request offset-1.
- en_toggle, input, 1, level; toggle enable on rising edge only (no repeat).
- scale, output, 4, committed scale to scaler.
- offset, output, 5, committed signed offset to scaler.
- enable, output, 1, committed enable, gated by sync_ok.
- sync_ok, output, 1, HS present.
- act_width, output, VW, widest HB-low run in the last frame. VW = 8/9/10 for SCREEN_WIDTH ≤256/≤512/else.
- commit, output, 1, one-clk pulse when shadow values are copied to outputs.

Behaviour:
Interface
- One clock, clk. Reset is synchronous and active-low (rst_n).
- Reset values: scale=SCALE_RST, offset=OFFSET_RST, enable=0, sync_ok=0, act_width=0, commit=0.
- Shadow registers reset to the same values; shadow enable=0. All counters reset to 0; FSM resets to IDLE.
- Reset mid-frame discards pending edits; outputs return to reset values on the next clk.

Edge detection
- VB, HS and all step inputs are registered each clk.
- Frame tick = VB rising edge.
- Line tick = HS rising edge, sampled on pxl_cen.

Step FSM (one per axis: scale, offset), advancing on frame ticks only:
- IDLE: the input-up or input-down line goes high → apply one step, go to HOLD with frame counter cleared.
- HOLD: counter reaches REPEAT_DLY → apply step, go to REPEAT.
- REPEAT: every REPEAT_PER frames → apply step.
- Any state: the held direction is released → IDLE.
- up and dn both high → no step; FSM holds in IDLE.
- Detection of a new press is at clk granularity: latched in a pending flag and applied at the next frame tick. At most one step per axis per frame.

Arithmetic
- scale saturates to the range 0..15.
- offset is 5-bit two's complement and saturates to the range -16..+15. No wrap-around.

Enable toggle
- Rising edge of en_toggle inverts shadow enable immediately in the shadow register.

Commit
- On the frame tick, outputs are copied from the shadow registers and commit pulses for one clk.
- A step applied on the same frame tick is included in that commit: the shadow update happens first, the copy uses the next-state value.

Width measurement (on pxl_cen)
- A run counter counts while HB=0 and clears on the HB rising edge, after comparing against frame_max.
- frame_max holds the largest run seen since the last frame tick.
- On the frame tick: act_width ← frame_max, then frame_max ← 0.
- Counters saturate at SCREEN_WIDTH-1.

Sync watchdog
- A pxl_cen counter clears on each line tick.
- Reaching HS_TIMEOUT → sync_ok=0.
- The next line tick → sync_ok=1.
- enable output = committed enable AND sync_ok, combinational AND of registers.
- Loss of sync does not alter the shadow registers.

Decomposition:
- Package jtframe_hsize_pkg: step FSM state enum (IDLE, HOLD, REPEAT), the VW width function, default constants SCALE_RST/OFFSET_RST.
- Sub-module jtframe_hsize_step: parameterised step/auto-repeat FSM with saturating counter (signed/unsigned parameter). Instantiated twice, once for scale and once for offset.

Test Plan:
1. Reset: drive rst_n=0 for 3 clk, then release → scale=8, offset=0, enable=0, commit=0, sync_ok=0.
2. Pulse scale_up for 2 clk mid-frame → scale stays 8 until the VB rise; then scale=9 with a single commit pulse.
3. Hold offset_dn for 40 frames from offset=0 → frame 1: -1; frame 25: -2; then -1 every 4 frames. After 40 frames: -5. Holding further saturates at -16 and never wraps to +15.
4. Hold scale_up and scale_dn together for 10 frames → scale unchanged at 8, no steps.
5. Line timing with HB low for 256 pixels, one line at 300 → act_width=300 after the next VB rise. A following frame with all lines 256 → act_width=256.
6. en_toggle pulse, then stop HS for 2048 pxl_cen → enable=1 after commit; falls to 0 when sync_ok drops. Restarting HS restores enable=1 with no re-commit needed.

Source files
------------

// File: rtl/jtframe_hsize_pkg.sv
// Shared types and helpers for the horizontal scaler configuration controller.
package jtframe_hsize_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } step_st_e;

    localparam logic [3:0] SCALE_RST_DEF  = 4'd8;
    localparam logic [4:0] OFFSET_RST_DEF = 5'd0;

    // Width of the active-width status counter for a given total line length.
    function automatic int vw(input int w);
        if (w <= 256) return 8;
        if (w <= 512) return 9;
        return 10;
    endfunction

endpackage

// File: rtl/jtframe_hsize_step.sv
// Step/auto-repeat FSM for one axis with a saturating shadow value.
// Advances on frame ticks; presses are latched at clk rate until the next tick.
module jtframe_hsize_step
    import jtframe_hsize_pkg::*;
#(
    parameter int             W         = 4,
    parameter bit             IS_SIGNED = 1'b0,
    parameter logic [W-1:0]   RST       = '0,
    parameter int             DLY       = 24,
    parameter int             PER       = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic         up_i,
    input  logic         dn_i,
    output logic [W-1:0] val_d_o
);

    localparam int            CW    = $clog2(DLY + 1);
    localparam logic [CW-1:0] DLY_C = CW'(DLY);
    localparam logic [CW-1:0] PER_C = CW'(PER);
    localparam logic [W-1:0]  VMAX  = IS_SIGNED ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};
    localparam logic [W-1:0]  VMIN  = IS_SIGNED ? {1'b1, {(W-1){1'b0}}} : {W{1'b0}};

    step_st_e      st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  val_q, val_d;
    logic          pup_q, pup_d, pdn_q, pdn_d, dir_q, dir_d;
    logic          step, held, other;

    // dir_q=1 means the held direction is up
    assign held  = dir_q ? up_i : dn_i;
    assign other = dir_q ? dn_i : up_i;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        val_d = val_q;
        pup_d = pup_q;
        pdn_d = pdn_q;
        dir_d = dir_q;
        step  = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (up_i && dn_i) begin
                    pup_d = 1'b0;
                    pdn_d = 1'b0;
                end else begin
                    pup_d = pup_q | up_i;
                    pdn_d = pdn_q | dn_i;
                end
                if (tick_i) begin
                    if (pup_d ^ pdn_d) begin
                        step  = 1'b1;
                        dir_d = pup_d;
                        st_d  = ST_HOLD;
                        cnt_d = '0;
                    end
                    pup_d = 1'b0;
                    pdn_d = 1'b0;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!held || other) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end else if (tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (st_q == ST_HOLD && cnt_d == DLY_C) begin
                        step  = 1'b1;
                        st_d  = ST_REPEAT;
                        cnt_d = '0;
                    end else if (st_q == ST_REPEAT && cnt_d == PER_C) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
        if (step) begin
            if (dir_d) val_d = (val_q == VMAX) ? val_q : val_q + 1'b1;
            else       val_d = (val_q == VMIN) ? val_q : val_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
            val_q <= RST;
            pup_q <= 1'b0;
            pdn_q <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            val_q <= val_d;
            pup_q <= pup_d;
            pdn_q <= pdn_d;
            dir_q <= dir_d;
        end
    end

    assign val_d_o = val_d;

endmodule

// File: rtl/jtframe_hsize_ctrl.sv
// Horizontal scaler configuration: shadowed user edits committed on VB rise,
// active-width measurement and an HS watchdog that forces bypass on sync loss.
module jtframe_hsize_ctrl
    import jtframe_hsize_pkg::*;
#(
    parameter int         SCREEN_WIDTH = 384,
    parameter logic [3:0] SCALE_RST    = SCALE_RST_DEF,
    parameter logic [4:0] OFFSET_RST   = OFFSET_RST_DEF,
    parameter int         REPEAT_DLY   = 24,
    parameter int         REPEAT_PER   = 4,
    parameter int         HS_TIMEOUT   = 2048
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pxl_cen,
    input  logic                         HS,
    input  logic                         HB,
    input  logic                         VB,
    input  logic                         scale_up,
    input  logic                         scale_dn,
    input  logic                         offset_up,
    input  logic                         offset_dn,
    input  logic                         en_toggle,
    output logic [3:0]                   scale,
    output logic [4:0]                   offset,
    output logic                         enable,
    output logic                         sync_ok,
    output logic [vw(SCREEN_WIDTH)-1:0]  act_width,
    output logic                         commit
);

    localparam int             VW      = vw(SCREEN_WIDTH);
    localparam int             WDW     = $clog2(HS_TIMEOUT + 1);
    localparam logic [VW-1:0]  RUN_MAX = VW'(SCREEN_WIDTH - 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(HS_TIMEOUT);

    logic           vb_q, hs_q, hb_q, su_q, sd_q, ou_q, od_q, et_q;
    logic           frame_tick, line_tick, hb_rise, tog;
    logic [3:0]     scale_sh_d, scale_q, scale_d;
    logic [4:0]     off_sh_d, offset_q, offset_d;
    logic           en_sh_q, en_sh_d, enable_q, enable_d, commit_q, commit_d;
    logic [VW-1:0]  run_q, run_d, fmax_q, fmax_d, act_q, act_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           sync_q, sync_d;

    assign frame_tick = VB & ~vb_q;
    assign line_tick  = pxl_cen & HS & ~hs_q;
    assign hb_rise    = pxl_cen & HB & ~hb_q;
    assign tog        = en_toggle & ~et_q;

    jtframe_hsize_step #(
        .W(4), .IS_SIGNED(1'b0), .RST(SCALE_RST), .DLY(REPEAT_DLY), .PER(REPEAT_PER)
    ) u_scale (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(frame_tick),
        .up_i(su_q), .dn_i(sd_q), .val_d_o(scale_sh_d)
    );

    jtframe_hsize_step #(
        .W(5), .IS_SIGNED(1'b1), .RST(OFFSET_RST), .DLY(REPEAT_DLY), .PER(REPEAT_PER)
    ) u_offset (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(frame_tick),
        .up_i(ou_q), .dn_i(od_q), .val_d_o(off_sh_d)
    );

    always_comb begin
        en_sh_d  = en_sh_q ^ tog;
        scale_d  = scale_q;
        offset_d = offset_q;
        enable_d = enable_q;
        commit_d = frame_tick;
        run_d    = run_q;
        fmax_d   = fmax_q;
        act_d    = act_q;
        wd_d     = wd_q;
        sync_d   = sync_q;
        // Commit takes the step modules' next-state so a same-tick step lands now
        if (frame_tick) begin
            scale_d  = scale_sh_d;
            offset_d = off_sh_d;
            enable_d = en_sh_d;
        end
        if (hb_rise) begin
            if (run_q > fmax_q) fmax_d = run_q;
            run_d = '0;
        end else if (pxl_cen && !HB && run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end
        if (frame_tick) begin
            act_d  = fmax_q;
            fmax_d = '0;
        end
        if (line_tick) begin
            wd_d   = '0;
            sync_d = 1'b1;
        end else if (pxl_cen && wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
            if (wd_d == WD_MAX) sync_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vb_q     <= 1'b0;
            hs_q     <= 1'b0;
            hb_q     <= 1'b0;
            su_q     <= 1'b0;
            sd_q     <= 1'b0;
            ou_q     <= 1'b0;
            od_q     <= 1'b0;
            et_q     <= 1'b0;
            en_sh_q  <= 1'b0;
            scale_q  <= SCALE_RST;
            offset_q <= OFFSET_RST;
            enable_q <= 1'b0;
            commit_q <= 1'b0;
            run_q    <= '0;
            fmax_q   <= '0;
            act_q    <= '0;
            wd_q     <= '0;
            sync_q   <= 1'b0;
        end else begin
            vb_q     <= VB;
            su_q     <= scale_up;
            sd_q     <= scale_dn;
            ou_q     <= offset_up;
            od_q     <= offset_dn;
            et_q     <= en_toggle;
            if (pxl_cen) begin
                hs_q <= HS;
                hb_q <= HB;
            end
            en_sh_q  <= en_sh_d;
            scale_q  <= scale_d;
            offset_q <= offset_d;
            enable_q <= enable_d;
            commit_q <= commit_d;
            run_q    <= run_d;
            fmax_q   <= fmax_d;
            act_q    <= act_d;
            wd_q     <= wd_d;
            sync_q   <= sync_d;
        end
    end

    assign scale     = scale_q;
    assign offset    = offset_q;
    assign enable    = enable_q & sync_q;
    assign sync_ok   = sync_q;
    assign act_width = act_q;
    assign commit    = commit_q;

endmodule

// File: tb/tb_jtframe_hsize_ctrl.sv
// Self-checking bench for jtframe_hsize_ctrl: per-feature tasks compared
// against a frame-count / max-width reference model.
module tb_jtframe_hsize_ctrl;

    localparam int VW = 9;

    logic          clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0;
    logic          HS = 1'b0, HB = 1'b1, VB = 1'b0;
    logic          scale_up = 1'b0, scale_dn = 1'b0, offset_up = 1'b0, offset_dn = 1'b0;
    logic          en_toggle = 1'b0;
    logic [3:0]    scale;
    logic [4:0]    offset;
    logic          enable, sync_ok, commit;
    logic [VW-1:0] act_width;

    int n_chk = 0, n_fail = 0, commit_cnt = 0, last_commits = 0;
    int cur_scale = 8, cur_off = 0;

    jtframe_hsize_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .HS(HS), .HB(HB), .VB(VB),
        .scale_up(scale_up), .scale_dn(scale_dn), .offset_up(offset_up),
        .offset_dn(offset_dn), .en_toggle(en_toggle), .scale(scale), .offset(offset),
        .enable(enable), .sync_ok(sync_ok), .act_width(act_width), .commit(commit)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        #1 pxl_cen = ~pxl_cen;
    end
    always @(negedge clk) if (commit === 1'b1) commit_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Steps applied after holding a direction for k frame ticks.
    function automatic int steps(input int k);
        if (k < 1)  return 0;
        if (k < 25) return 1;
        return 2 + (k - 25) / 4;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One pixel spans two clk, exactly one of which carries pxl_cen.
    task automatic pix(input logic hb, input logic hs, input int n);
        HB = hb;
        HS = hs;
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic frame_vb();
        int c0;
        c0 = commit_cnt;
        VB = 1'b1;
        tick(6);
        VB = 1'b0;
        tick(4);
        last_commits = commit_cnt - c0;
    endtask

    task automatic line(input int w);
        pix(1'b1, 1'b1, 4);
        pix(1'b1, 1'b0, 36);
        pix(1'b0, 1'b0, w);
    endtask

    task automatic end_frame();
        pix(1'b1, 1'b0, 10);
        frame_vb();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        n_chk++; if (scale !== 4'd8) begin n_fail++; $display("FAIL reset_scale: got %0d want 8", scale); end
        n_chk++; if (offset !== 5'd0) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", offset); end
        n_chk++; if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", enable); end
        n_chk++; if (commit !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b want 0", commit); end
        n_chk++; if (sync_ok !== 1'b0) begin n_fail++; $display("FAIL reset_sync_ok: got %b want 0", sync_ok); end
        n_chk++; if (act_width !== 9'd0) begin n_fail++; $display("FAIL reset_act_width: got %0d want 0", act_width); end
    endtask

    task automatic test_both();
        scale_up = 1'b1;
        scale_dn = 1'b1;
        tick(3);
        for (int f = 1; f <= 10; f++) begin
            frame_vb();
            n_chk++; if (scale !== 4'd8) begin n_fail++; $display("FAIL both_scale f%0d: got %0d want 8", f, scale); end
            n_chk++; if (last_commits != 1) begin n_fail++; $display("FAIL both_commits f%0d: got %0d want 1", f, last_commits); end
        end
        scale_up = 1'b0;
        scale_dn = 1'b0;
        tick(3);
    endtask

    task automatic test_single_step();
        scale_up = 1'b1;
        tick(2);
        scale_up = 1'b0;
        tick(20);
        n_chk++; if (scale !== 4'd8) begin n_fail++; $display("FAIL step_midframe: got %0d want 8", scale); end
        frame_vb();
        n_chk++; if (scale !== 4'd9) begin n_fail++; $display("FAIL step_commit: got %0d want 9", scale); end
        n_chk++; if (last_commits != 1) begin n_fail++; $display("FAIL step_pulses: got %0d want 1", last_commits); end
        frame_vb();
        n_chk++; if (scale !== 4'd9) begin n_fail++; $display("FAIL step_norepeat: got %0d want 9", scale); end
        cur_scale = 9;
    endtask

    task automatic test_hold_repeat();
        int exp;
        offset_dn = 1'b1;
        tick(3);
        for (int f = 1; f <= 90; f++) begin
            frame_vb();
            exp = clampi(-steps(f), -16, 15);
            n_chk++;
            if (offset !== 5'(exp)) begin
                n_fail++;
                $display("FAIL hold_offset f%0d: got %0d want %0d", f, $signed(offset), exp);
            end
        end
        offset_dn = 1'b0;
        tick(3);
        cur_off = -16;
    endtask

    task automatic test_random_steps();
        for (int t = 0; t < 8; t++) begin
            int axis, up, n, start, exp;
            axis  = int'($urandom_range(0, 1));
            up    = int'($urandom_range(0, 1));
            n     = int'($urandom_range(1, 45));
            start = axis ? cur_off : cur_scale;
            exp   = start;
            if (axis == 0) begin scale_up  = (up == 1); scale_dn  = (up == 0); end
            else           begin offset_up = (up == 1); offset_dn = (up == 0); end
            tick(int'($urandom_range(2, 6)));
            for (int f = 1; f <= n; f++) begin
                frame_vb();
                if (axis == 0) begin
                    exp = clampi(start + (up ? 1 : -1) * steps(f), 0, 15);
                    n_chk++;
                    if (scale !== 4'(exp)) begin
                        n_fail++;
                        $display("FAIL rnd_scale t%0d f%0d: got %0d want %0d", t, f, scale, exp);
                    end
                end else begin
                    exp = clampi(start + (up ? 1 : -1) * steps(f), -16, 15);
                    n_chk++;
                    if (offset !== 5'(exp)) begin
                        n_fail++;
                        $display("FAIL rnd_offset t%0d f%0d: got %0d want %0d", t, f, $signed(offset), exp);
                    end
                end
            end
            scale_up = 1'b0; scale_dn = 1'b0; offset_up = 1'b0; offset_dn = 1'b0;
            tick(3);
            if (axis == 0) cur_scale = exp;
            else           cur_off   = exp;
        end
    endtask

    task automatic test_width();
        int mx, w;
        line(256); line(300); line(256);
        end_frame();
        n_chk++; if (act_width !== 9'd300) begin n_fail++; $display("FAIL width_300: got %0d want 300", act_width); end
        n_chk++; if (last_commits != 1) begin n_fail++; $display("FAIL width_commit: got %0d want 1", last_commits); end
        line(256); line(256); line(256);
        end_frame();
        n_chk++; if (act_width !== 9'd256) begin n_fail++; $display("FAIL width_256: got %0d want 256", act_width); end
        mx = 0;
        for (int i = 0; i < 3; i++) begin
            w = int'($urandom_range(50, 383));
            line(w);
            if (w > mx) mx = w;
        end
        end_frame();
        n_chk++; if (act_width !== 9'(mx)) begin n_fail++; $display("FAIL width_rnd: got %0d want %0d", act_width, mx); end
        line(420);
        end_frame();
        n_chk++; if (act_width !== 9'd383) begin n_fail++; $display("FAIL width_sat: got %0d want 383", act_width); end
        n_chk++; if (sync_ok !== 1'b1) begin n_fail++; $display("FAIL width_sync: got %b want 1", sync_ok); end
    endtask

    task automatic test_sync_enable();
        int t, c0;
        line(100); line(100);
        pix(1'b1, 1'b0, 4);
        en_toggle = 1'b1;
        tick(2);
        en_toggle = 1'b0;
        tick(2);
        frame_vb();
        n_chk++; if (enable !== 1'b1) begin n_fail++; $display("FAIL sync_en_commit: got %b want 1", enable); end
        n_chk++; if (last_commits != 1) begin n_fail++; $display("FAIL sync_commit: got %0d want 1", last_commits); end
        pix(1'b1, 1'b1, 2);
        pix(1'b1, 1'b0, 0);
        t = 0;
        while (sync_ok === 1'b1 && t < 6000) begin
            tick(1);
            t++;
        end
        n_chk++; if (sync_ok !== 1'b0) begin n_fail++; $display("FAIL sync_lost: got %b want 0 after %0d clk", sync_ok, t); end
        n_chk++; if (t < 4080 || t > 4110) begin n_fail++; $display("FAIL sync_timeout_clk: got %0d want 4080..4110", t); end
        n_chk++; if (enable !== 1'b0) begin n_fail++; $display("FAIL sync_bypass: got %b want 0", enable); end
        c0 = commit_cnt;
        line(100);
        pix(1'b1, 1'b0, 4);
        n_chk++; if (sync_ok !== 1'b1) begin n_fail++; $display("FAIL sync_restore: got %b want 1", sync_ok); end
        n_chk++; if (enable !== 1'b1) begin n_fail++; $display("FAIL sync_en_restore: got %b want 1", enable); end
        n_chk++; if (commit_cnt != c0) begin n_fail++; $display("FAIL sync_no_commit: got %0d want %0d", commit_cnt, c0); end
    endtask

    task automatic test_reset_mid();
        scale_up  = 1'b1;
        offset_up = 1'b1;
        tick(3);
        rst_n     = 1'b0;
        scale_up  = 1'b0;
        offset_up = 1'b0;
        tick(1);
        n_chk++; if (scale !== 4'd8) begin n_fail++; $display("FAIL rstmid_scale: got %0d want 8", scale); end
        n_chk++; if (offset !== 5'd0) begin n_fail++; $display("FAIL rstmid_offset: got %0d want 0", offset); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        n_chk++; if (enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_enable: got %b want 0", enable); end
        n_chk++; if (sync_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_sync: got %b want 0", sync_ok); end
        n_chk++; if (act_width !== 9'd0) begin n_fail++; $display("FAIL rstmid_width: got %0d want 0", act_width); end
        frame_vb();
        n_chk++; if (scale !== 4'd8) begin n_fail++; $display("FAIL rstmid_pending_scale: got %0d want 8", scale); end
        n_chk++; if (offset !== 5'd0) begin n_fail++; $display("FAIL rstmid_pending_offset: got %0d want 0", offset); end
    endtask

    initial begin
        test_reset();
        test_both();
        test_single_step();
        test_hold_repeat();
        test_random_steps();
        test_width();
        test_sync_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
